// File: rtl/pipe_field_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_field_if : game-control, bird box, pixel query and status bus   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pipe_field_if;
    logic        i_tick;
    logic        i_start;
    logic [11:0] i_bird_x1;
    logic [11:0] i_bird_x2;
    logic [11:0] i_bird_y1;
    logic [11:0] i_bird_y2;
    logic [9:0]  i_px;
    logic [9:0]  i_py;
    logic        o_pipe_px;
    logic        o_point_add;
    logic        o_dead;
    logic [1:0]  o_state;

    modport master (
        output i_tick, i_start, i_bird_x1, i_bird_x2, i_bird_y1, i_bird_y2, i_px, i_py,
        input  o_pipe_px, o_point_add, o_dead, o_state
    );

    modport slave (
        input  i_tick, i_start, i_bird_x1, i_bird_x2, i_bird_y1, i_bird_y2, i_px, i_py,
        output o_pipe_px, o_point_add, o_dead, o_state
    );
endinterface
`default_nettype wire

// File: rtl/pipe_field.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_field : N scrolling pipe pairs, game FSM, scoring and collision |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_field #(
    parameter int unsigned N_PIPES   = 3,
    parameter int unsigned X_SIZE    = 40,
    parameter int unsigned Y_HOLE    = 80,
    parameter int unsigned SPACING   = 240,
    parameter int unsigned SPEED     = 4,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned FLOOR_Y   = 450,
    parameter int unsigned HOLE_MIN  = 60,
    parameter int unsigned HOLE_MAX  = 380,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  wire logic   i_clk,
    input  wire logic   i_rst,
    pipe_field_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    localparam logic [11:0] C_HOLE_MID = 12'((HOLE_MIN + HOLE_MAX) / 2);
    localparam logic [11:0] C_HOLE_MIN = 12'(HOLE_MIN);
    localparam logic [11:0] C_HALF     = 12'(Y_HOLE / 2);
    localparam logic [11:0] C_X_SIZE   = 12'(X_SIZE);
    localparam logic [11:0] C_SPEED    = 12'(SPEED);
    localparam logic [11:0] C_WRAP     = 12'(N_PIPES * SPACING - SPEED);
    localparam logic [11:0] C_FLOOR    = 12'(FLOOR_Y);
    localparam logic [9:0]  C_RANGE    = 10'(HOLE_MAX - HOLE_MIN + 1);

    state_t             r_state, w_state_next;
    logic [11:0]        r_x2 [N_PIPES];
    logic [11:0]        r_c  [N_PIPES];
    logic [15:0]        r_lfsr;
    logic               r_point;
    logic               r_pipe_px;

    logic [15:0]        w_lfsr_next;
    logic [9:0]         w_v;
    logic [11:0]        w_px, w_py;
    logic [N_PIPES-1:0] w_bird_hit, w_px_hit, w_cross, w_respawn;
    logic [11:0]        w_x2_step [N_PIPES];
    logic               w_collide, w_run_tick;

    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    // Gap offset folded into [0, R) with a single subtract; R >= 256 makes one enough.
    assign w_v  = ({1'b0, r_lfsr[8:0]} >= C_RANGE) ? ({1'b0, r_lfsr[8:0]} - C_RANGE)
                                                   : {1'b0, r_lfsr[8:0]};
    assign w_px = {2'b00, bus.i_px};
    assign w_py = {2'b00, bus.i_py};

    for (genvar k = 0; k < N_PIPES; k++) begin : g_pipe
        logic [11:0] w_lo, w_top, w_bot;
        assign w_lo  = (r_x2[k] < C_X_SIZE) ? 12'd0 : (r_x2[k] - C_X_SIZE);
        assign w_top = r_c[k] - C_HALF;
        assign w_bot = r_c[k] + C_HALF;

        assign w_bird_hit[k] = (bus.i_bird_x1 < r_x2[k]) && (bus.i_bird_x2 >= w_lo) &&
                               ((bus.i_bird_y1 < w_top) || (bus.i_bird_y2 >= w_bot));
        assign w_px_hit[k]   = (w_px >= w_lo) && (w_px < r_x2[k]) &&
                               ((w_py < w_top) || (w_py >= w_bot));
        assign w_respawn[k]  = (r_x2[k] <= C_SPEED);
        assign w_x2_step[k]  = w_respawn[k] ? (r_x2[k] + C_WRAP) : (r_x2[k] - C_SPEED);
        assign w_cross[k]    = (r_x2[k] >= bus.i_bird_x1) && (w_x2_step[k] < bus.i_bird_x1);
    end

    assign w_collide  = (|w_bird_hit) || (bus.i_bird_y2 >= C_FLOOR) || (bus.i_bird_y1 == 12'd0);
    assign w_run_tick = (r_state == ST_RUN) && bus.i_tick;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.i_start) w_state_next = ST_RUN;
            ST_RUN:  if (bus.i_tick && w_collide) w_state_next = ST_DEAD;
            ST_DEAD: if (bus.i_start) w_state_next = ST_RUN;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_lfsr    <= LFSR_SEED;
            r_point   <= 1'b0;
            r_pipe_px <= 1'b0;
            for (int k = 0; k < N_PIPES; k++) begin
                r_x2[k] <= 12'(SCREEN_W + X_SIZE + k * SPACING);
                r_c[k]  <= C_HOLE_MID;
            end
        end else begin
            r_state   <= w_state_next;
            r_point   <= w_run_tick && !w_collide && (|w_cross);
            r_pipe_px <= |w_px_hit;
            if (w_run_tick)
                r_lfsr <= w_lfsr_next;
            // A fatal tick freezes the pipes where the bird hit them.
            for (int k = 0; k < N_PIPES; k++) begin
                if (r_state == ST_DEAD && bus.i_start) begin
                    r_x2[k] <= 12'(SCREEN_W + X_SIZE + k * SPACING);
                    r_c[k]  <= C_HOLE_MID;
                end else if (w_run_tick && !w_collide) begin
                    r_x2[k] <= w_x2_step[k];
                    if (w_respawn[k])
                        r_c[k] <= C_HOLE_MIN + {2'b00, w_v};
                end
            end
        end
    end

    assign bus.o_state     = r_state;
    assign bus.o_dead      = (r_state == ST_DEAD);
    assign bus.o_point_add = r_point;
    assign bus.o_pipe_px   = r_pipe_px;
endmodule
`default_nettype wire

// File: tb/tb_pipe_field.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_field : directed scoreboard bench for pipe_field             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_field;
    localparam int N = 3, XS = 40, YH = 80, SP = 240, SPD = 4, SW = 640;
    localparam int FY = 450, HMIN = 60, HMAX = 380, R = HMAX - HMIN + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_field_if bus();
    pipe_field dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

    int          mx2 [N];
    int          mc  [N];
    logic [15:0] mlfsr;
    int          mstate;
    int          checks = 0;
    int          errors = 0;
    logic        px_q [$];
    logic        pt_q [$];

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset_pipes();
        for (int k = 0; k < N; k++) begin
            mx2[k] = SW + XS + k * SP;
            mc[k]  = (HMIN + HMAX) / 2;
        end
    endtask

    function automatic bit in_body(int k, int x, int y);
        int lo;
        lo = (mx2[k] < XS) ? 0 : mx2[k] - XS;
        return (x >= lo) && (x < mx2[k]) && ((y < mc[k] - YH / 2) || (y >= mc[k] + YH / 2));
    endfunction

    task automatic set_bird(input int x1, input int x2, input int y1, input int y2);
        bus.i_bird_x1 = 12'(x1);
        bus.i_bird_x2 = 12'(x2);
        bus.i_bird_y1 = 12'(y1);
        bus.i_bird_y2 = 12'(y2);
    endtask

    // exp < 0: expectation comes from the pipe model only.
    task automatic query(input string tag, input int x, input int y, input int exp);
        logic e;
        e = 1'b0;
        for (int k = 0; k < N; k++) e |= in_body(k, x, y);
        if (exp >= 0) e = exp[0];
        bus.i_px = 10'(x);
        bus.i_py = 10'(y);
        px_q.push_back(e);
        @(posedge clk); #1;
        check(tag, {11'd0, bus.o_pipe_px}, {11'd0, px_q.pop_front()});
    endtask

    task automatic do_tick();
        int  bx1, bx2, by1, by2, lo, v, nx;
        bit  coll, pt;
        bx1 = int'(bus.i_bird_x1); bx2 = int'(bus.i_bird_x2);
        by1 = int'(bus.i_bird_y1); by2 = int'(bus.i_bird_y2);
        pt = 1'b0;
        if (mstate == 1) begin
            coll = (by2 >= FY) || (by1 == 0);
            for (int k = 0; k < N; k++) begin
                lo = (mx2[k] < XS) ? 0 : mx2[k] - XS;
                if (bx1 < mx2[k] && bx2 >= lo &&
                    (by1 < mc[k] - YH / 2 || by2 >= mc[k] + YH / 2)) coll = 1'b1;
            end
            v = int'(mlfsr[8:0]);
            if (v >= R) v -= R;
            mlfsr = {1'b0, mlfsr[15:1]} ^ (mlfsr[0] ? 16'hB400 : 16'h0000);
            if (coll) mstate = 2;
            else begin
                for (int k = 0; k < N; k++) begin
                    if (mx2[k] <= SPD) begin
                        nx = mx2[k] + N * SP - SPD;
                        mc[k] = HMIN + v;
                    end else nx = mx2[k] - SPD;
                    if (mx2[k] >= bx1 && nx < bx1) pt = 1'b1;
                    mx2[k] = nx;
                end
            end
        end
        pt_q.push_back(pt);
        bus.i_tick = 1'b1;
        @(posedge clk); #1;
        bus.i_tick = 1'b0;
        check("tick_state", 12'(mstate), {10'd0, bus.o_state});
        check("tick_dead", {11'd0, bus.o_dead}, {11'd0, mstate == 2});
        check("point", {11'd0, bus.o_point_add}, {11'd0, pt_q.pop_front()});
        @(posedge clk); #1;
        check("point_width", {11'd0, bus.o_point_add}, 12'd0);
    endtask

    task automatic restart();
        if (mstate == 2) model_reset_pipes();
        mstate = 1;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check("start_state", {10'd0, bus.o_state}, 12'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_tick = 1'b0; bus.i_start = 1'b0;
        bus.i_px = 10'd660; bus.i_py = 10'd50;
        set_bird(150, 170, 200, 230);
        mlfsr = 16'hACE1; mstate = 0; model_reset_pipes();
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {10'd0, bus.o_state}, 12'd0);
        check("rst_dead", {11'd0, bus.o_dead}, 12'd0);
        check("rst_point", {11'd0, bus.o_point_add}, 12'd0);
        check("rst_pipe_px", {11'd0, bus.o_pipe_px}, 12'd0);
        rst = 1'b0;

        query("idle_px_660_50", 660, 50, 1);
        query("idle_px_660_220", 660, 220, 0);
        query("idle_px_639_edge", 639, 50, 0);
        query("idle_px_679_179", 679, 179, 1);
        query("idle_px_679_180", 679, 180, 0);
        query("idle_px_679_259", 679, 259, 0);
        query("idle_px_679_260", 679, 260, 1);
        query("idle_px_680", 680, 50, 0);

        // Bird in the gap: pipe 0 crosses x=150 at tick 133, respawns at tick 170.
        restart();
        for (int t = 0; t < 170; t++) do_tick();
        check("run_dead_low", {11'd0, bus.o_dead}, 12'd0);
        query("respawn_above_gap", 719, mc[0] - YH / 2 - 1, 1);
        query("respawn_gap_top", 719, mc[0] - YH / 2, 0);
        query("respawn_gap_bot", 719, mc[0] + YH / 2 - 1, 0);
        query("respawn_below_gap", 719, mc[0] + YH / 2, 1);
        query("respawn_right_edge", 720, 10, 0);

        // Bird above the gap meets pipe 1.
        set_bird(150, 170, 100, 120);
        for (int t = 0; t < 20 && mstate == 1; t++) do_tick();
        check("above_gap_dead", {11'd0, bus.o_dead}, 12'd1);
        check("above_gap_state", {10'd0, bus.o_state}, 12'd2);
        query("frozen_in", mx2[1] - 1, 50, 1);
        query("frozen_out", mx2[1], 50, 0);
        do_tick();
        query("frozen_after_tick", mx2[1] - 1, 50, 1);
        bus.i_start = 1'b0;

        // Restart: positions reload, lfsr carries on.
        set_bird(150, 170, 200, 230);
        restart();
        query("restart_px_660_50", 660, 50, 1);
        query("restart_px_679_200", 679, 200, 0);
        bus.i_start = 1'b1;
        do_tick();
        bus.i_start = 1'b0;
        for (int t = 1; t < 170; t++) do_tick();
        query("respawn2_above_gap", 719, mc[0] - YH / 2 - 1, 1);
        query("respawn2_gap_top", 719, mc[0] - YH / 2, 0);
        query("respawn2_below_gap", 719, mc[0] + YH / 2, 1);

        // Floor.
        set_bird(150, 170, 420, 450);
        do_tick();
        check("floor_dead", {11'd0, bus.o_dead}, 12'd1);

        // Point crossing and collision on the same tick.
        set_bird(150, 170, 200, 230);
        restart();
        for (int t = 0; t < 132; t++) do_tick();
        set_bird(150, 170, 420, 450);
        do_tick();
        check("same_tick_dead", {11'd0, bus.o_dead}, 12'd1);

        // Ceiling.
        set_bird(150, 170, 0, 30);
        restart();
        do_tick();
        check("ceiling_dead", {11'd0, bus.o_dead}, 12'd1);

        // Reset in the middle of a run.
        set_bird(150, 170, 200, 230);
        restart();
        for (int t = 0; t < 5; t++) do_tick();
        bus.i_px = 10'd660; bus.i_py = 10'd50;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrun_rst_state", {10'd0, bus.o_state}, 12'd0);
        check("midrun_rst_pipe_px", {11'd0, bus.o_pipe_px}, 12'd0);
        rst = 1'b0;
        mlfsr = 16'hACE1; mstate = 0; model_reset_pipes();
        query("midrun_rst_px_660_50", 660, 50, 1);
        query("midrun_rst_px_636", 636, 50, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_field.md
Name: pipe_field

Overview:
- Parametrised successor to the single-pipe generator: manages N_PIPES scrolling pipe pairs with LFSR-randomised gap heights.
- Owns the game-run state machine, point pulses and bird/pipe/floor collision.
- Answers per-pixel "is pipe" queries for the VGA colour mux.
- Runs entirely on the board clock; physics advance is gated by a one-cycle tick strobe.

Parameters:
N_PIPES, 3, number of simultaneously tracked pipes (1..8)
X_SIZE, 40, pipe column width in pixels
Y_HOLE, 80, gap height in pixels (even)
SPACING, 240, horizontal distance between consecutive pipes; N_PIPES*SPACING >= SCREEN_W+X_SIZE and SPACING > SPEED required
SPEED, 4, pixels scrolled per tick
SCREEN_W, 640, visible width
FLOOR_Y, 450, y at or below which the bird is dead
HOLE_MIN, 60, minimum gap centre
HOLE_MAX, 380, maximum gap centre; range R = HOLE_MAX-HOLE_MIN+1 must satisfy 256 <= R <= 512
LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
i_clk  in  1  board clock
i_rst  in  1  synchronous active-high reset
i_tick  in  1  one-cycle physics strobe (25 Hz)
i_start  in  1  start/restart request (level sampled each cycle)
i_bird_x1, i_bird_x2, i_bird_y1, i_bird_y2  in  12 each  bird bounding box, x1<x2, y1<y2
i_px  in  10  pixel x query
i_py  in  10  pixel y query
o_pipe_px  out  1  query pixel lies in a pipe body (registered)
o_point_add  out  1  one-cycle score pulse
o_dead  out  1  high while in DEAD
o_state  out  2  00 IDLE, 01 RUN, 10 DEAD

Behaviour:
- Reset (i_rst, overrides everything):
  - state IDLE; lfsr=LFSR_SEED.
  - Pipe k: right edge x2[k]=SCREEN_W+X_SIZE+k*SPACING; gap centre c[k]=(HOLE_MIN+HOLE_MAX)/2.
  - All outputs 0, o_state=00.
- Pipe k body: columns x2[k]-X_SIZE <= x < x2[k], with the lower bound clamped to 0 when x2[k] < X_SIZE. Rows outside [c[k]-Y_HOLE/2, c[k]+Y_HOLE/2).
- FSM:
  - IDLE: i_start -> RUN next cycle. Pipes hold.
  - RUN: on each i_tick, update pipes, lfsr, points and collision, as below.
  - DEAD: pipes and lfsr frozen. i_start -> RUN next cycle, with all x2[k] and c[k] reloaded to reset values; lfsr is NOT reseeded.
- RUN tick update, all in the same clock edge:
  - lfsr advances one step: 16-bit Galois, mask 16'hB400.
  - For each k: if x2[k] <= SPEED, then x2[k] <= x2[k]+N_PIPES*SPACING-SPEED (respawn) and c[k] <= HOLE_MIN+v. Otherwise x2[k] <= x2[k]-SPEED.
  - v = lfsr[8:0], minus R when lfsr[8:0] >= R (single conditional subtract). The pre-advance lfsr value is used.
  - At most one respawn per tick, guaranteed by the SPACING constraint.
- Point: o_point_add=1 for exactly one cycle, the cycle after a RUN tick in which some x2[k] goes from >= i_bird_x1 to < i_bird_x1. Never pulses outside RUN.
- Collision: evaluated combinationally from the current registers and bird box, and acted on only at a RUN tick. Any of:
  - the bird box overlaps a pipe body;
  - i_bird_y2 >= FLOOR_Y;
  - i_bird_y1 == 0.
  - Result: state -> DEAD at that edge, o_dead=1 from the next cycle, and pipes do not move on that tick.
- Collision and point on the same tick: collision wins, no o_point_add.
- i_start while in RUN is ignored.
- o_pipe_px: 1-cycle latency, registered OR over k of (i_px inside column k AND i_py outside gap k). Valid in every state, including IDLE and DEAD. It is 0 during reset.
- Arithmetic: x2 and c are 12-bit unsigned. Comparisons use unsigned 12-bit values, with i_px and i_py zero-extended.

Test Plan:
- Reset, then i_start pulse: o_state 00 -> 01 one cycle later. x2 = {680, 920, 1160}; c = 220.
- 170 ticks in RUN (4 px each): x2[0] reaches 0 mod-respawn at tick 170. x2[0] becomes 4+720-4=720 and c[0] equals HOLE_MIN plus the reduced lfsr[8:0].
- Bird box x 150..170, y 200..230 held inside the gap, ticks until x2[0] crosses 150. Exactly one o_point_add pulse, one cycle after that tick; o_dead stays 0.
- Bird box y 100..120 (above gap 180..260) as pipe 0 overlaps x 150..170. Next tick gives o_state=10, o_dead=1, x2 frozen. Then i_start gives RUN with reset positions and an lfsr that is not the seed.
- Bird y2=450 on a tick gives DEAD. Repeat with the point crossing on the same tick: DEAD and no o_point_add.
- Pixel query with i_px=660, i_py=50 after reset gives o_pipe_px=1 one cycle later. i_py=220 gives 0. i_rst asserted mid-RUN gives all state back to reset values on the next edge.
